pending_table_ctrl: RTL and testbench

- Sequencer/arbiter in front of the node2noc pending-transaction table.
- Shares the table's single insert port among N_MASTERS local WISHBONE masters using round-robin arbitration.
- Runs the table's query/delete port for the noc2node reply path through a small FSM.
- Keeps an occupancy count so no insert is granted while the table is full.

---
 rtl/pending_table_ctrl_pkg.sv | 23 ++
 rtl/pending_table_ctrl_if.sv | 70 +++++++
 rtl/pending_table_ctrl_rr_arbiter.sv | 31 +++
 rtl/pending_table_ctrl.sv | 148 ++++++++++++++
 tb/tb_pending_table_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pending_table_ctrl_pkg.sv
// Shared widths, depth and reply-FSM encodings for the pending-transaction table controller.
package pending_table_ctrl_pkg;

  localparam int BUS_ADDRESS_WIDTH             = 8;
  localparam int N_BITS_COHERENCE_MESSAGE_TYPE = 4;
  localparam int TABLE_PENDING_NODE2NOC_WIDTH  = 8;

  typedef logic [BUS_ADDRESS_WIDTH-1:0]             addr_t;
  typedef logic [N_BITS_COHERENCE_MESSAGE_TYPE-1:0] msg_type_t;

  typedef struct packed {
    addr_t     sender;
    addr_t     recipient;
    msg_type_t mtype;
  } key_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_QUERY = 2'd1,
    ST_RESP  = 2'd2
  } rep_state_e;

endpackage

// File: rtl/pending_table_ctrl_if.sv
// Insert, reply and table-port bundle of pending_table_ctrl.
// Stats outputs exist only when PENDING_TABLE_CTRL_STATS_EN is defined.
interface pending_table_ctrl_if #(
  parameter int N_MASTERS = 4
);
  import pending_table_ctrl_pkg::*;

  logic [N_MASTERS-1:0]                               ins_req_i;
  logic [N_MASTERS*BUS_ADDRESS_WIDTH-1:0]             ins_sender_i;
  logic [N_MASTERS*BUS_ADDRESS_WIDTH-1:0]             ins_recipient_i;
  logic [N_MASTERS*N_BITS_COHERENCE_MESSAGE_TYPE-1:0] ins_type_i;
  logic [N_MASTERS-1:0]                               ins_gnt_o;

  logic      rep_req_i;
  addr_t     rep_sender_i;
  addr_t     rep_recipient_i;
  msg_type_t rep_type_i;
  logic      rep_delete_i;
  logic      rep_ready_o;
  logic      rep_done_o;
  logic      rep_hit_o;

  logic       full_o;
  logic [3:0] count_o;

  logic      tbl_new_o;
  addr_t     tbl_new_sender_o;
  addr_t     tbl_new_recipient_o;
  msg_type_t tbl_new_type_o;
  logic      tbl_query_o;
  addr_t     tbl_query_sender_o;
  addr_t     tbl_query_recipient_o;
  msg_type_t tbl_query_type_o;
  logic      tbl_delete_o;
  logic      tbl_hit_i;

`ifdef PENDING_TABLE_CTRL_STATS_EN
  logic [15:0] stat_miss_o;
  logic [15:0] stat_stall_o;
`endif

  modport slave (
`ifdef PENDING_TABLE_CTRL_STATS_EN
    output stat_miss_o, stat_stall_o,
`endif
    input  ins_req_i, ins_sender_i, ins_recipient_i, ins_type_i,
    output ins_gnt_o,
    input  rep_req_i, rep_sender_i, rep_recipient_i, rep_type_i, rep_delete_i,
    output rep_ready_o, rep_done_o, rep_hit_o, full_o, count_o,
    output tbl_new_o, tbl_new_sender_o, tbl_new_recipient_o, tbl_new_type_o,
    output tbl_query_o, tbl_query_sender_o, tbl_query_recipient_o, tbl_query_type_o,
    output tbl_delete_o,
    input  tbl_hit_i
  );

  modport master (
`ifdef PENDING_TABLE_CTRL_STATS_EN
    input  stat_miss_o, stat_stall_o,
`endif
    output ins_req_i, ins_sender_i, ins_recipient_i, ins_type_i,
    input  ins_gnt_o,
    output rep_req_i, rep_sender_i, rep_recipient_i, rep_type_i, rep_delete_i,
    input  rep_ready_o, rep_done_o, rep_hit_o, full_o, count_o,
    input  tbl_new_o, tbl_new_sender_o, tbl_new_recipient_o, tbl_new_type_o,
    input  tbl_query_o, tbl_query_sender_o, tbl_query_recipient_o, tbl_query_type_o,
    input  tbl_delete_o,
    output tbl_hit_i
  );

endinterface

// File: rtl/pending_table_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins (wrapping).
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W-1:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = 0; k < N; k++) begin
      pos = PTR_W'((int'(ptr) + k) % N);
      if (en && !any && req[pos]) begin
        gnt[pos] = 1'b1;
        idx      = pos;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pending_table_ctrl.sv
// Round-robin insert arbiter, reply lookup FSM and occupancy counter for the pending table.
// Optional miss/stall statistics are enabled by defining PENDING_TABLE_CTRL_STATS_EN.
module pending_table_ctrl
  import pending_table_ctrl_pkg::*;
#(
  parameter int N_MASTERS     = 4,
  parameter int N_BITS_MASTER = 2,
  parameter int N_BITS_COUNT  = 4
) (
  input logic                 clk,
  input logic                 rst,
  pending_table_ctrl_if.slave bus
);

  localparam int AW = BUS_ADDRESS_WIDTH;
  localparam int TW = N_BITS_COHERENCE_MESSAGE_TYPE;

  rep_state_e               state, state_nxt;
  logic [N_BITS_MASTER-1:0] rr_ptr;
  logic [N_BITS_MASTER-1:0] gnt_idx;
  logic [N_MASTERS-1:0]     gnt;
  logic                     gnt_any;
  logic [N_BITS_COUNT-1:0]  count;
  logic                     full;
  key_t                     key_p0;
  logic                     del_p0;
  logic                     hit_p1;
  logic                     query;
  logic                     dec;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign full = (count == N_BITS_COUNT'(TABLE_PENDING_NODE2NOC_WIDTH));

  // Full blocks grants even when a delete frees a slot this cycle.
  rr_arbiter #(.N(N_MASTERS), .PTR_W(N_BITS_MASTER)) u_arb (
    .req (bus.ins_req_i),
    .ptr (rr_ptr),
    .en  (!full && !rst),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    bus.tbl_new_sender_o    = '0;
    bus.tbl_new_recipient_o = '0;
    bus.tbl_new_type_o      = '0;
    for (int m = 0; m < N_MASTERS; m++) begin
      if (gnt[m]) begin
        bus.tbl_new_sender_o    = bus.ins_sender_i[m*AW +: AW];
        bus.tbl_new_recipient_o = bus.ins_recipient_i[m*AW +: AW];
        bus.tbl_new_type_o      = bus.ins_type_i[m*TW +: TW];
      end
    end
  end

  assign bus.ins_gnt_o = gnt;
  assign bus.tbl_new_o = gnt_any;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.rep_ready_o = 1'b0;
    query           = 1'b0;
    bus.rep_done_o  = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.rep_ready_o = !rst;
        if (bus.rep_req_i) state_nxt = ST_QUERY;
      end
      ST_QUERY: begin
        query     = !rst;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus.rep_done_o = !rst;
        state_nxt      = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: lookup key captured on accept.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.rep_req_i) begin
      key_p0 <= '{sender: bus.rep_sender_i, recipient: bus.rep_recipient_i, mtype: bus.rep_type_i};
      del_p0 <= bus.rep_delete_i;
    end
  end

  assign bus.tbl_query_o           = query;
  assign bus.tbl_query_sender_o    = key_p0.sender;
  assign bus.tbl_query_recipient_o = key_p0.recipient;
  assign bus.tbl_query_type_o      = key_p0.mtype;
  assign bus.tbl_delete_o          = query && del_p0;

  // Stage p1: table hit registered during QUERY, held until the next lookup.
  always_ff @(posedge clk) begin
    if (rst)        hit_p1 <= 1'b0;
    else if (query) hit_p1 <= bus.tbl_hit_i;
  end

  assign bus.rep_hit_o = hit_p1;
  assign dec           = query && del_p0 && bus.tbl_hit_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      rr_ptr <= '0;
    end else begin
      case ({gnt_any, dec})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (gnt_any)
        rr_ptr <= (gnt_idx == N_BITS_MASTER'(N_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign bus.count_o = count;
  assign bus.full_o  = full;

`ifdef PENDING_TABLE_CTRL_STATS_EN
  logic [15:0] stat_miss, stat_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_miss  <= '0;
      stat_stall <= '0;
    end else begin
      if (state == ST_RESP && !hit_p1) stat_miss <= sat_inc16(stat_miss);
      if (|bus.ins_req_i && full)      stat_stall <= sat_inc16(stat_stall);
    end
  end

  assign bus.stat_miss_o  = stat_miss;
  assign bus.stat_stall_o = stat_stall;
`endif

endmodule

// File: tb/tb_pending_table_ctrl.sv
// Bench for pending_table_ctrl: vector table for arbitration/fill, hand sequences for lookups and reset.
module tb_pending_table_ctrl;
  import pending_table_ctrl_pkg::*;

  localparam int NM = 4;
  localparam int AW = BUS_ADDRESS_WIDTH;
  localparam int TW = N_BITS_COHERENCE_MESSAGE_TYPE;
  localparam int D  = TABLE_PENDING_NODE2NOC_WIDTH;

  logic clk;
  logic rst;
  int   n_vec, n_fail, cyc;

  pending_table_ctrl_if #(.N_MASTERS(NM)) bus ();

  pending_table_ctrl #(.N_MASTERS(NM), .N_BITS_MASTER(2), .N_BITS_COUNT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural table: combinational hit, write/delete at the clock edge.
  logic      mv [D];
  addr_t     ms [D];
  addr_t     mr [D];
  msg_type_t mt [D];
  logic      hit_m, free_ok;
  int        hit_idx, free_idx;

  always_comb begin
    hit_m = 1'b0; hit_idx = 0; free_ok = 1'b0; free_idx = 0;
    for (int i = 0; i < D; i++) begin
      if (!hit_m && mv[i] && ms[i] == bus.tbl_query_sender_o &&
          mr[i] == bus.tbl_query_recipient_o && mt[i] == bus.tbl_query_type_o) begin
        hit_m = 1'b1; hit_idx = i;
      end
      if (!free_ok && !mv[i]) begin
        free_ok = 1'b1; free_idx = i;
      end
    end
  end

  assign bus.tbl_hit_i = hit_m;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) mv[i] <= 1'b0;
    end else begin
      if (bus.tbl_query_o && bus.tbl_delete_o && hit_m) mv[hit_idx] <= 1'b0;
      if (bus.tbl_new_o && free_ok) begin
        mv[free_idx] <= 1'b1;
        ms[free_idx] <= bus.tbl_new_sender_o;
        mr[free_idx] <= bus.tbl_new_recipient_o;
        mt[free_idx] <= bus.tbl_new_type_o;
      end
    end
  end

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] count;
    logic       full;
  } vec_t;

  typedef struct {
    logic hit;
    int   acc;
  } sb_t;

  vec_t      vecs [12];
  sb_t       sb [$];
  addr_t     msend [NM];
  addr_t     mrecp [NM];
  msg_type_t mtyp  [NM];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_keys();
    for (int m = 0; m < NM; m++) begin
      bus.ins_sender_i[m*AW +: AW]    = msend[m];
      bus.ins_recipient_i[m*AW +: AW] = mrecp[m];
      bus.ins_type_i[m*TW +: TW]      = mtyp[m];
    end
  endtask

  // Negedge sample point; also retires scoreboard entries on rep_done_o.
  task automatic sample();
    sb_t e;
    @(negedge clk);
    if (bus.rep_done_o) begin
      if (sb.size() == 0) chk("unexpected_done", bus.rep_done_o, 0);
      else begin
        e = sb.pop_front();
        chk("rep_hit", bus.rep_hit_o, e.hit);
        chk("done_latency", cyc - e.acc, 2);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic lookup(input addr_t s, input addr_t r, input msg_type_t t,
                        input logic del, input logic exp_hit);
    sb_t e;
    bus.rep_req_i = 1'b1; bus.rep_sender_i = s; bus.rep_recipient_i = r;
    bus.rep_type_i = t; bus.rep_delete_i = del;
    sample();
    chk("rep_ready_accept", bus.rep_ready_o, 1);
    e.hit = exp_hit; e.acc = cyc; sb.push_back(e);
    advance();
    bus.rep_req_i = 1'b0;
    sample(); advance();
    sample(); advance();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sb_t e;
    n_vec = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    bus.ins_req_i = '0; bus.rep_req_i = 1'b0; bus.rep_delete_i = 1'b0;
    bus.rep_sender_i = '0; bus.rep_recipient_i = '0; bus.rep_type_i = '0;
    for (int m = 0; m < NM; m++) begin
      msend[m] = addr_t'(8'h40 + m); mrecp[m] = addr_t'(8'h50 + m); mtyp[m] = msg_type_t'(m);
    end
    drive_keys();

    //          req      gnt      count  full
    vecs[0]  = '{4'b0101, 4'b0001, 4'd0, 1'b0};
    vecs[1]  = '{4'b0101, 4'b0100, 4'd1, 1'b0};
    vecs[2]  = '{4'b0101, 4'b0001, 4'd2, 1'b0};
    vecs[3]  = '{4'b0101, 4'b0100, 4'd3, 1'b0};
    vecs[4]  = '{4'b0000, 4'b0000, 4'd4, 1'b0};
    vecs[5]  = '{4'b1111, 4'b1000, 4'd4, 1'b0};
    vecs[6]  = '{4'b0010, 4'b0010, 4'd5, 1'b0};
    vecs[7]  = '{4'b0011, 4'b0001, 4'd6, 1'b0};
    vecs[8]  = '{4'b1000, 4'b1000, 4'd7, 1'b0};
    vecs[9]  = '{4'b1111, 4'b0000, 4'd8, 1'b1};
    vecs[10] = '{4'b1111, 4'b0000, 4'd8, 1'b1};
    vecs[11] = '{4'b0000, 4'b0000, 4'd8, 1'b1};

    sample(); advance();
    sample(); advance();
    rst = 1'b0;
    sample();
    chk("rst_count", bus.count_o, 0);
    chk("rst_full", bus.full_o, 0);
    chk("rst_ready", bus.rep_ready_o, 1);
    chk("rst_done", bus.rep_done_o, 0);
    chk("rst_hit", bus.rep_hit_o, 0);
    chk("rst_new", bus.tbl_new_o, 0);
    chk("rst_query", bus.tbl_query_o, 0);
    advance();

    for (int i = 0; i < 12; i++) begin
      bus.ins_req_i = vecs[i].req;
      sample();
      chk($sformatf("v%0d_gnt", i), bus.ins_gnt_o, vecs[i].gnt);
      chk($sformatf("v%0d_new", i), bus.tbl_new_o, |vecs[i].gnt);
      chk($sformatf("v%0d_count", i), bus.count_o, vecs[i].count);
      chk($sformatf("v%0d_full", i), bus.full_o, vecs[i].full);
      for (int m = 0; m < NM; m++)
        if (vecs[i].gnt[m]) chk($sformatf("v%0d_new_sender", i), bus.tbl_new_sender_o, msend[m]);
      advance();
    end
    bus.ins_req_i = '0;
    sample();
    chk("fill_count", bus.count_o, 8);
`ifdef PENDING_TABLE_CTRL_STATS_EN
    chk("stat_stall", bus.stat_stall_o, 2);
`endif
    advance();

    // Full table: hit-delete and pending insert coincide; grant follows a cycle later.
    bus.ins_req_i = 4'b0100;
    bus.rep_req_i = 1'b1; bus.rep_sender_i = msend[1]; bus.rep_recipient_i = mrecp[1];
    bus.rep_type_i = mtyp[1]; bus.rep_delete_i = 1'b1;
    sample();
    chk("fd_ready", bus.rep_ready_o, 1);
    chk("fd_gnt_a", bus.ins_gnt_o, 0);
    e.hit = 1'b1; e.acc = cyc; sb.push_back(e);
    advance();
    bus.rep_req_i = 1'b0;
    sample();
    chk("fd_query", bus.tbl_query_o, 1);
    chk("fd_delete", bus.tbl_delete_o, 1);
    chk("fd_gnt_q", bus.ins_gnt_o, 0);
    chk("fd_count_q", bus.count_o, 8);
    advance();
    sample();
    chk("fd_gnt_r", bus.ins_gnt_o, 4'b0100);
    chk("fd_count_r", bus.count_o, 7);
    chk("fd_full_r", bus.full_o, 0);
    advance();
    bus.ins_req_i = '0;
    sample();
    chk("fd_count_after", bus.count_o, 8);
    chk("fd_full_after", bus.full_o, 1);
    advance();

    // Free a slot, insert key 10/20/3 from master 1, then hit-delete it.
    lookup(msend[3], mrecp[3], mtyp[3], 1'b1, 1'b1);
    msend[1] = 8'h10; mrecp[1] = 8'h20; mtyp[1] = 4'd3;
    drive_keys();
    bus.ins_req_i = 4'b0010;
    sample();
    chk("ins_gnt", bus.ins_gnt_o, 4'b0010);
    chk("ins_sender", bus.tbl_new_sender_o, 8'h10);
    chk("ins_recipient", bus.tbl_new_recipient_o, 8'h20);
    chk("ins_type", bus.tbl_new_type_o, 3);
    chk("ins_count_before", bus.count_o, 7);
    advance();
    bus.ins_req_i = '0;
    lookup(8'h10, 8'h20, 4'd3, 1'b1, 1'b1);
    sample();
    chk("hitdel_count", bus.count_o, 7);
    advance();

    lookup(8'h99, 8'h99, 4'd5, 1'b1, 1'b0);
    sample();
    chk("miss_count", bus.count_o, 7);
`ifdef PENDING_TABLE_CTRL_STATS_EN
    chk("stat_miss_1", bus.stat_miss_o, 1);
`endif
    advance();

    // Lookup of a key inserted in the QUERY cycle itself must miss.
    msend[0] = 8'h77; mrecp[0] = 8'h66; mtyp[0] = 4'd2;
    drive_keys();
    bus.rep_req_i = 1'b1; bus.rep_sender_i = 8'h77; bus.rep_recipient_i = 8'h66;
    bus.rep_type_i = 4'd2; bus.rep_delete_i = 1'b1;
    sample();
    chk("same_ready", bus.rep_ready_o, 1);
    e.hit = 1'b0; e.acc = cyc; sb.push_back(e);
    advance();
    bus.rep_req_i = 1'b0; bus.ins_req_i = 4'b0001;
    sample();
    chk("same_query", bus.tbl_query_o, 1);
    chk("same_gnt", bus.ins_gnt_o, 4'b0001);
    advance();
    bus.ins_req_i = '0;
    sample(); advance();
    sample();
    chk("same_count", bus.count_o, 8);
`ifdef PENDING_TABLE_CTRL_STATS_EN
    chk("stat_miss_2", bus.stat_miss_o, 2);
`endif
    advance();

    lookup(8'h77, 8'h66, 4'd2, 1'b0, 1'b1);
    sample();
    chk("nodel_count", bus.count_o, 8);
    chk("hit_hold", bus.rep_hit_o, 1);
    advance();

    // Reset while in QUERY: lookup dropped with no done pulse.
    bus.rep_req_i = 1'b1; bus.rep_delete_i = 1'b1;
    sample();
    chk("rq_ready", bus.rep_ready_o, 1);
    advance();
    bus.rep_req_i = 1'b0; rst = 1'b1;
    sample(); advance();
    rst = 1'b0;
    sample();
    chk("rq_done", bus.rep_done_o, 0);
    chk("rq_ready_after", bus.rep_ready_o, 1);
    chk("rq_count", bus.count_o, 0);
    chk("rq_full", bus.full_o, 0);
    chk("rq_hit", bus.rep_hit_o, 0);
    advance();
    for (int i = 0; i < 3; i++) begin
      sample(); advance();
    end
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
